// File: rtl/mc_control_unit.sv
// Multicycle RV32 control FSM: sequences the datapath, owns the memory
// req/ready handshake, counts retired instructions and flags bad opcodes.
//   in : clk, reset (async, active low), op, func3, func7b5, Zero, mem_ready
//   out: mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCWrite, ResultSrc,
//        ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, instret
module mc_control_unit #(
  parameter int CNT_W   = 32,
  parameter bit EN_JALR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic             func7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             PCWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  logic       req_c, mw_c, rw_c, ir_c, pcw_c, ill_c;
  logic       adr_c;
  logic [1:0] rs_c, a_c, b_c;
  logic [2:0] alu_c, alu_dec;

  // ALU operation for EXECUTER / EXECUTEI
  always_comb begin
    alu_dec = ALU_ADD;
    case (func3)
      3'b000:  alu_dec = (op == OP_R && func7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      default:  ImmSrc = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_R:     state_d = S_EXECR;
          OP_I:     state_d = S_EXECI;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = EN_JALR ? S_JALR1 : S_FETCH;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // an instruction retires on its final transition back into FETCH
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_JALR2:    retire = 1'b1;
      S_MEMWRITE: retire = mem_ready;
      default:    retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_comb begin
    req_c = 1'b0;
    mw_c  = 1'b0;
    rw_c  = 1'b0;
    ir_c  = 1'b0;
    pcw_c = 1'b0;
    ill_c = 1'b0;
    adr_c = 1'b0;
    rs_c  = 2'b00;
    a_c   = 2'b00;
    b_c   = 2'b00;
    alu_c = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        b_c   = 2'b10;
        rs_c  = 2'b10;
        ir_c  = mem_ready;
        pcw_c = mem_ready;
      end
      S_DECODE: begin
        a_c = 2'b01;
        b_c = 2'b01;
        case (op)
          OP_LOAD, OP_STORE, OP_R, OP_I,
          OP_BR, OP_JAL: ill_c = 1'b0;
          OP_JALR:       ill_c = !EN_JALR;
          default:       ill_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        a_c = 2'b10;
        b_c = 2'b01;
      end
      S_MEMREAD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
      end
      S_MEMWB: begin
        rs_c = 2'b01;
        rw_c = 1'b1;
      end
      S_MEMWRITE: begin
        req_c = 1'b1;
        mw_c  = 1'b1;
        adr_c = 1'b1;
      end
      S_EXECR: begin
        a_c   = 2'b10;
        alu_c = alu_dec;
      end
      S_EXECI: begin
        a_c   = 2'b10;
        b_c   = 2'b01;
        alu_c = alu_dec;
      end
      S_ALUWB: rw_c = 1'b1;
      S_BRANCH: begin
        a_c   = 2'b10;
        alu_c = ALU_SUB;
        case (func3)
          3'b000:  pcw_c = Zero;
          3'b001:  pcw_c = !Zero;
          default: pcw_c = 1'b0;
        endcase
      end
      S_JAL: begin
        a_c   = 2'b01;
        b_c   = 2'b10;
        pcw_c = 1'b1;
      end
      S_JALR1: begin
        a_c   = 2'b10;
        b_c   = 2'b01;
        rs_c  = 2'b10;
        pcw_c = 1'b1;
      end
      S_JALR2: begin
        a_c  = 2'b01;
        b_c  = 2'b10;
        rs_c = 2'b10;
        rw_c = 1'b1;
      end
      default: ;
    endcase
  end

  // reset is asynchronous, so enables are also gated directly by it
  assign mem_req    = req_c & reset;
  assign MemWrite   = mw_c & reset;
  assign RegWrite   = rw_c & reset;
  assign IRWrite    = ir_c & reset;
  assign PCWrite    = pcw_c & reset;
  assign illegal    = ill_c & reset;
  assign AdrSrc     = adr_c;
  assign ResultSrc  = rs_c;
  assign ALUSrcA    = a_c;
  assign ALUSrcB    = b_c;
  assign ALUControl = alu_c;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit.
// Checks per-cycle control signatures, stalls, reset and instret.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7b5;
  logic       Zero;
  logic       mem_ready;

  logic        mem_req, MemWrite, RegWrite, IRWrite, AdrSrc, PCWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc, ALUControl;
  logic        illegal;
  logic [31:0] instret;

  logic        mem_req2, MemWrite2, RegWrite2, IRWrite2, AdrSrc2, PCWrite2;
  logic [1:0]  ResultSrc2, ALUSrcA2, ALUSrcB2;
  logic [2:0]  ImmSrc2, ALUControl2;
  logic        illegal2;
  logic [2:0]  instret2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.CNT_W(32), .EN_JALR(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .func7b5(func7b5), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .PCWrite(PCWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
    .instret(instret)
  );

  mc_control_unit #(.CNT_W(3), .EN_JALR(1'b0)) u_nojalr (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .func7b5(func7b5), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
    .IRWrite(IRWrite2), .AdrSrc(AdrSrc2), .PCWrite(PCWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .illegal(illegal2),
    .instret(instret2)
  );

  // {illegal,mem_req,MemWrite,RegWrite,IRWrite,AdrSrc,PCWrite,
  //  ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  logic [15:0] obs;
  assign obs = {illegal, mem_req, MemWrite, RegWrite, IRWrite, AdrSrc,
                PCWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

  localparam logic [15:0] F_RDY = {7'b0100101, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [15:0] F_STL = {7'b0100000, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [15:0] DEC   = {7'b0000000, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [15:0] DECIL = {7'b1000000, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [15:0] MADR  = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [15:0] MRD   = {7'b0100010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] MWB   = {7'b0001000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] MWR   = {7'b0110010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] AWB   = {7'b0001000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] JAL   = {7'b0000001, 2'b00, 2'b01, 2'b10, 3'b000};
  localparam logic [15:0] JR1   = {7'b0000001, 2'b10, 2'b10, 2'b01, 3'b000};
  localparam logic [15:0] JR2   = {7'b0001000, 2'b10, 2'b01, 2'b10, 3'b000};

  function automatic logic [15:0] exr(input logic [2:0] alu);
    return {7'b0, 2'b00, 2'b10, 2'b00, alu};
  endfunction

  function automatic logic [15:0] exi(input logic [2:0] alu);
    return {7'b0, 2'b00, 2'b10, 2'b01, alu};
  endfunction

  function automatic logic [15:0] br(input logic p);
    return {6'b0, p, 2'b00, 2'b10, 2'b00, 3'b001};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check current cycle's outputs, then advance one clock
  task automatic st(input string tag, input logic [15:0] e);
    #1;
    chk(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] o, input logic [2:0] f3,
                     input logic f7);
    op      = o;
    func3   = f3;
    func7b5 = f7;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    Zero      = 1'b0;
    ins(7'b0100011, 3'b010, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'({mem_req, MemWrite, RegWrite, IRWrite, PCWrite,
                       illegal}), 32'd0);
    chk("rst_cnt", instret, 32'd0);
    reset = 1'b1;

    // sw interrupted by reset in the middle of a stalled write
    mem_ready = 1'b1;
    st("sw0_f", F_RDY);
    st("sw0_d", DEC);
    st("sw0_a", MADR);
    mem_ready = 1'b0;
    st("sw0_w", MWR);
    reset = 1'b0;
    #1;
    chk("midrst_en", 32'({mem_req, MemWrite}), 32'd0);
    chk("midrst_cnt", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // fetch stall, then add
    ins(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) st("fstall", F_STL);
    mem_ready = 1'b1;
    st("f_rdy", F_RDY);
    st("add_d", DEC);
    st("add_x", exr(3'b000));
    st("add_wb", AWB);
    chk("cnt_add", instret, 32'd1);

    ins(7'b0110011, 3'b000, 1'b1);
    st("sub_f", F_RDY);
    st("sub_d", DEC);
    st("sub_x", exr(3'b001));
    st("sub_wb", AWB);
    chk("cnt_sub", instret, 32'd2);

    // lw with 2-cycle read stall
    ins(7'b0000011, 3'b010, 1'b0);
    st("lw_f", F_RDY);
    st("lw_d", DEC);
    st("lw_a", MADR);
    mem_ready = 1'b0;
    st("lw_r0", MRD);
    st("lw_r1", MRD);
    mem_ready = 1'b1;
    st("lw_r2", MRD);
    st("lw_wb", MWB);
    chk("cnt_lw", instret, 32'd3);

    // sw with 1-cycle write stall
    ins(7'b0100011, 3'b010, 1'b0);
    #1;
    chk("imm_s", 32'(ImmSrc), 32'd1);
    st("sw_f", F_RDY);
    st("sw_d", DEC);
    st("sw_a", MADR);
    mem_ready = 1'b0;
    st("sw_w0", MWR);
    mem_ready = 1'b1;
    st("sw_w1", MWR);
    chk("cnt_sw", instret, 32'd4);

    // addi with func7b5=1 must stay add
    ins(7'b0010011, 3'b000, 1'b1);
    #1;
    chk("imm_i", 32'(ImmSrc), 32'd0);
    st("addi_f", F_RDY);
    st("addi_d", DEC);
    st("addi_x", exi(3'b000));
    st("addi_wb", AWB);

    ins(7'b0110011, 3'b111, 1'b0);
    st("and_f", F_RDY);
    st("and_d", DEC);
    st("and_x", exr(3'b010));
    st("and_wb", AWB);
    chk("cnt_and", instret, 32'd6);

    // beq taken, bne not taken (Zero=1)
    Zero = 1'b1;
    ins(7'b1100011, 3'b000, 1'b0);
    #1;
    chk("imm_b", 32'(ImmSrc), 32'd2);
    st("beq_f", F_RDY);
    st("beq_d", DEC);
    st("beq_b", br(1'b1));
    chk("cnt_beq", instret, 32'd7);

    ins(7'b1100011, 3'b001, 1'b0);
    st("bne_f", F_RDY);
    st("bne_d", DEC);
    st("bne_b", br(1'b0));
    chk("cnt_bne", instret, 32'd8);
    chk("cnt3_wrap", 32'(instret2), 32'd0);
    Zero = 1'b0;

    ins(7'b1101111, 3'b000, 1'b0);
    #1;
    chk("imm_j", 32'(ImmSrc), 32'd3);
    st("jal_f", F_RDY);
    st("jal_d", DEC);
    st("jal_j", JAL);
    st("jal_wb", AWB);
    chk("cnt_jal", instret, 32'd9);
    chk("cnt3_jal", 32'(instret2), 32'd1);

    // jalr: supported on main instance, illegal on the other
    ins(7'b1100111, 3'b000, 1'b0);
    st("jalr_f", F_RDY);
    #1;
    chk("jalr_ill2", 32'(illegal2), 32'd1);
    st("jalr_d", DEC);
    st("jalr_1", JR1);
    st("jalr_2", JR2);
    chk("cnt_jalr", instret, 32'd10);

    // unsupported opcode
    ins(7'b1111111, 3'b000, 1'b0);
    st("ill_f", F_RDY);
    st("ill_d", DECIL);
    st("ill_back", F_RDY);
    chk("cnt_ill", instret, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM that sequences the RV32 multicycle datapath: drives register, IR and PC write enables, the mux selects, ImmSrc and ALUControl from the decoded instruction fields and the Zero flag.
- Instruction and data memory sit outside the CPU. This block owns the memory request/ready handshake and stalls the datapath until memory responds.
- Also counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- EN_JALR, 1, when 1 jalr is supported; when 0 jalr is treated as illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  InstrReg[6:0].
- func3  in  3  InstrReg[14:12].
- func7b5  in  1  InstrReg[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  external memory completed the current access this cycle.
- mem_req  out  1  memory access requested.
- MemWrite  out  1  memory write strobe.
- RegWrite, IRWrite, AdrSrc, PCWrite  out  1 each  datapath enables/select.
- ResultSrc, ALUSrcA, ALUSrcB  out  2 each  mux selects.
- ImmSrc  out  3  immediate format.
- ALUControl  out  3  ALU operation.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Encodings:
  - ALUSrcA: 00 PC, 01 OldPC, 10 A.
  - ALUSrcB: 00 WriteData, 01 ImmExt, 10 const 4.
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
  - AdrSrc: 0 PC, 1 Result.
  - ImmSrc is decoded combinationally from op in every state: I 000 (0000011/0010011/1100111), S 001 (0100011), B 010 (1100011), J 011 (1101111); other op values 000.
  - ALUControl: add 000, sub 001, and 010, or 011, xor 100, slt 101.
- ALU decode, used in EXECUTER and EXECUTEI; all other states force add, except BRANCH which forces sub:
  - func3 000: sub only when op=0110011 and func7b5=1, otherwise add.
  - func3 010: slt. 100: xor. 110: or. 111: and.
  - Any other func3: add.
- States, outputs and transitions; any signal not listed is 0:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut<=OldPC+imm).
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 with EN_JALR=1 -> JALR1
    - anything else -> FETCH with illegal=1 for one cycle; instret not incremented.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Stay until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Stay until mem_ready, then FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
    - PCWrite=Zero when func3=000; PCWrite=~Zero when func3=001; any other func3 gives PCWrite=0.
    - -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
  - JALR1: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1 -> JALR2.
  - JALR2: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1 -> FETCH.
- instret: increments by 1 on the transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or JALR2. Wraps at 2^CNT_W-1 -> 0.
- Reset:
  - While reset=0: state=FETCH, instret=0, illegal=0, and all enables (mem_req, MemWrite, RegWrite, IRWrite, PCWrite) forced 0, including mid-instruction or mid-stall.
  - First cycle after release: FETCH with mem_req=1.
- Memory latency is unbounded. Outputs hold steady throughout a stall; no write enable other than the handshake-gated ones asserts during a stall.
- An unencoded state returns to FETCH on the next edge.

Test Plan:
- Reset low mid-MEMWRITE with mem_ready=0 -> MemWrite=0, mem_req=0 immediately; instret=0. After release: FETCH, mem_req=1.
- FETCH with mem_ready low 3 cycles, then high -> IRWrite=PCWrite=0 for 3 cycles, 1 on cycle 4; DECODE on the next edge.
- add (op=0110011, func3=000, func7b5=0), then sub (func7b5=1), mem_ready=1 -> each takes 4 cycles. EXECUTER ALUControl=000, then 001. RegWrite=1 only in ALUWB. instret=2.
- lw with a 2-cycle read stall -> 7 cycles total. RegWrite=1 with ResultSrc=01 exactly once. sw -> MemWrite held until mem_ready, RegWrite never 1.
- beq Zero=1 -> PCWrite=1 in BRANCH. bne (func3=001) Zero=1 -> PCWrite=0. Both take 3 cycles and increment instret.
- op=7'b1111111 -> illegal pulses 1 cycle in DECODE, back to FETCH, instret unchanged. jalr with EN_JALR=0 -> illegal=1.
